// File: rtl/branch_pc_sequencer.sv
// -----------------------------------------------------------------------------
// branch_pc_sequencer
//
// Multi-cycle control FSM that walks each instruction through
// FETCH -> DECODE -> EXECUTE -> WRITEBACK, owns the program counter and the
// instruction-memory request handshake, and gates the carry-flag and
// register-file write strobes.
//
// Handshake: in FETCH, imem_req is held high with imem_addr = pc until the
// memory answers with imem_ack for one cycle; that same cycle ir_load pulses
// and the FSM moves on. A fetch that sees no ack for FETCH_TIMEOUT cycles
// halts the machine with fetch_err set and pc unchanged.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   imem_req/ack/addr instruction fetch handshake
//   ir_load           one-cycle instruction-register load strobe
//   alu_instr         decoded instruction is an ALU op (sampled in DECODE)
//   wb_needed         decoded instruction writes the register file (DECODE)
//   halt_instr        decoded instruction is halt (DECODE)
//   branch_condn      branch decision (sampled in EXECUTE)
//   branch_target     branch target (sampled in EXECUTE)
//   resume            restart from HALT
//   flag_en           carry-flag register enable (EXECUTE of ALU ops)
//   reg_we            register-file write enable (WRITEBACK)
//   pc                current program counter
//   state             FSM state (FETCH=0 DECODE=1 EXECUTE=2 WRITEBACK=3 HALT=4)
//   halted            FSM is in HALT
//   fetch_err         sticky: last halt came from a fetch timeout
//   retired           saturating count of retired instructions
// -----------------------------------------------------------------------------
module branch_pc_sequencer #(
    parameter int                 ADDR_W        = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC      = '0,
    parameter int                 FETCH_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    input  logic              imem_ack,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              ir_load,
    input  logic              alu_instr,
    input  logic              wb_needed,
    input  logic              halt_instr,
    input  logic              branch_condn,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              resume,
    output logic              flag_en,
    output logic              reg_we,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic              fetch_err,
    output logic [15:0]       retired
);

    localparam int CNT_W = $clog2(FETCH_TIMEOUT + 1);
    // The counter value that, after one more ack-less cycle, reaches the limit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_WRITEBACK = 3'd3,
        S_HALT      = 3'd4
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       retired_q;
    logic              fetch_err_q;
    logic [CNT_W-1:0]  cnt_q;

    // Instruction attributes captured in DECODE / EXECUTE
    logic              alu_q;
    logic              wb_q;
    logic              br_q;
    logic [ADDR_W-1:0] tgt_q;

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] pc_d;
    logic [15:0]       retired_d;

    // pc + 4 wraps naturally modulo 2^ADDR_W
    assign pc_plus4  = pc_q + ADDR_W'(4);
    // Branch targets are forced to word alignment
    assign pc_d      = br_q ? {tgt_q[ADDR_W-1:2], 2'b00} : pc_plus4;
    assign retired_d = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            retired_q   <= '0;
            fetch_err_q <= 1'b0;
            cnt_q       <= '0;
            alu_q       <= 1'b0;
            wb_q        <= 1'b0;
            br_q        <= 1'b0;
            tgt_q       <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // An ack wins even in the cycle the limit would be reached
                    if (imem_ack) begin
                        cnt_q   <= '0;
                        state_q <= S_DECODE;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q       <= '0;
                        fetch_err_q <= 1'b1;
                        state_q     <= S_HALT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (halt_instr) begin
                        // The halt itself retires; resume continues after it
                        pc_q      <= pc_plus4;
                        retired_q <= retired_d;
                        state_q   <= S_HALT;
                    end else begin
                        alu_q   <= alu_instr;
                        wb_q    <= wb_needed;
                        state_q <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    br_q    <= branch_condn;
                    tgt_q   <= branch_target;
                    state_q <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    pc_q      <= pc_d;
                    retired_q <= retired_d;
                    state_q   <= S_FETCH;
                end
                S_HALT: begin
                    if (resume) begin
                        fetch_err_q <= 1'b0;
                        state_q     <= S_FETCH;
                    end
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Strobes are decoded from state and latched bits; reset suppresses them
    // in the reset cycle itself so no stray pulse escapes mid-instruction.
    assign imem_req  = !reset && (state_q == S_FETCH);
    assign ir_load   = !reset && (state_q == S_FETCH) && imem_ack;
    assign flag_en   = !reset && (state_q == S_EXECUTE) && alu_q;
    assign reg_we    = !reset && (state_q == S_WRITEBACK) && wb_q;
    assign halted    = !reset && (state_q == S_HALT);

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign state     = state_q;
    assign fetch_err = fetch_err_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_branch_pc_sequencer
//
// Directed bench. Driver tasks push the expected observable events (fetch,
// flag enable, register write, entry into HALT) into exp_q; a monitor pops
// and compares whenever the DUT shows one of those events.
// Event word: {kind[2:0], pc[31:0], retired[15:0], fetch_err}.
// -----------------------------------------------------------------------------
module tb_branch_pc_sequencer;

    localparam int W = 52;
    localparam logic [2:0] K_FETCH = 3'd1;
    localparam logic [2:0] K_FLAG  = 3'd2;
    localparam logic [2:0] K_WE    = 3'd3;
    localparam logic [2:0] K_HALT  = 3'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_addr;
    logic        ir_load;
    logic        alu_instr;
    logic        wb_needed;
    logic        halt_instr;
    logic        branch_condn;
    logic [31:0] branch_target;
    logic        resume;
    logic        flag_en;
    logic        reg_we;
    logic [31:0] pc;
    logic [2:0]  state;
    logic        halted;
    logic        fetch_err;
    logic [15:0] retired;

    logic [W-1:0] exp_q[$];
    int check_cnt = 0;
    int err_cnt   = 0;
    int req_cycles = 0;
    int exp_ret   = 0;
    logic halted_prev = 1'b0;

    branch_pc_sequencer #(
        .ADDR_W(32), .RESET_PC(32'h0), .FETCH_TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_addr(imem_addr),
        .ir_load(ir_load), .alu_instr(alu_instr), .wb_needed(wb_needed),
        .halt_instr(halt_instr), .branch_condn(branch_condn),
        .branch_target(branch_target), .resume(resume),
        .flag_en(flag_en), .reg_we(reg_we), .pc(pc), .state(state),
        .halted(halted), .fetch_err(fetch_err), .retired(retired)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [2:0] k, input logic [31:0] a,
                                        input logic [15:0] r, input logic f);
        return {k, a, r, f};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        check_cnt++;
        if (act !== expv) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic observe(input logic [2:0] k, input string name);
        logic [W-1:0] act;
        logic [W-1:0] expv;
        act = mk(k, pc, retired, fetch_err);
        check_cnt++;
        if (exp_q.size() == 0) begin
            err_cnt++;
            $display("FAIL %s: unexpected event got 0x%013h expected none", name, act);
        end else begin
            expv = exp_q.pop_front();
            if (act !== expv) begin
                err_cnt++;
                $display("FAIL %s: got 0x%013h expected 0x%013h", name, act, expv);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req) req_cycles++;
            if (ir_load) observe(K_FETCH, "fetch");
            if (flag_en) observe(K_FLAG, "flag_en");
            if (reg_we)  observe(K_WE, "reg_we");
            if (halted && !halted_prev) observe(K_HALT, "halt_entry");
        end
        halted_prev = halted;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction starting in FETCH at addr. Returns one cycle into the
    // next FETCH, or one cycle into HALT for a halt instruction.
    task automatic instr(input int wait_cyc, input logic res_in_fetch,
                         input logic alu, input logic wb, input logic hlt,
                         input logic br, input logic [31:0] tgt,
                         input logic [31:0] addr);
        exp_q.push_back(mk(K_FETCH, addr, 16'(exp_ret), 1'b0));
        imem_ack = 1'b0;
        resume   = res_in_fetch;
        repeat (wait_cyc) step();
        resume        = 1'b0;
        imem_ack      = 1'b1;
        alu_instr     = alu;
        wb_needed     = wb;
        halt_instr    = hlt;
        branch_condn  = br;
        branch_target = tgt;
        if (hlt) begin
            exp_q.push_back(mk(K_HALT, addr + 32'd4, 16'(exp_ret + 1), 1'b0));
        end else begin
            if (alu) exp_q.push_back(mk(K_FLAG, addr, 16'(exp_ret), 1'b0));
            if (wb)  exp_q.push_back(mk(K_WE, addr, 16'(exp_ret), 1'b0));
        end
        step();
        imem_ack = 1'b0;
        step();
        if (!hlt) begin
            step();
            step();
        end
        exp_ret++;
        alu_instr = 1'b0; wb_needed = 1'b0; halt_instr = 1'b0;
        branch_condn = 1'b0; branch_target = 32'h0;
    endtask

    task automatic do_resume();
        resume = 1'b1;
        step();
        resume = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; imem_ack = 1'b0; alu_instr = 1'b0; wb_needed = 1'b0;
        halt_instr = 1'b0; branch_condn = 1'b0; branch_target = 32'h0; resume = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fetch_err", 32'(fetch_err), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Three straight-line instructions, zero-wait memory
        instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
        instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8);
        chk("t1_pc", pc, 32'hC);
        chk("t1_retired", 32'(retired), 32'd3);
        chk("t1_req_cycles", 32'(req_cycles), 32'd3);

        // ALU op writing back, with one memory wait state
        instr(1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'hC);
        // Halt at 0x10
        instr(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h10);
        chk("t5_halted", 32'(halted), 32'd1);
        chk("t5_pc", pc, 32'h14);
        chk("t5_retired", 32'(retired), 32'd5);
        do_resume();
        chk("t5_state_after_resume", 32'(state), 32'd0);
        // Resume held during FETCH wait cycles must be ignored
        instr(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h14);
        instr(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h18);
        // Not-taken branch: target ignored
        instr(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h55, 32'h1C);
        // Taken branch at 0x20 to 0x103 -> aligned 0x100
        instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h103, 32'h20);
        chk("t2_pc_taken", pc, 32'h100);
        instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h42, 32'h100);
        chk("t2_pc_0x40", pc, 32'h40);

        // Fetch timeout at 0x40
        exp_q.push_back(mk(K_HALT, 32'h40, 16'(exp_ret), 1'b1));
        imem_ack = 1'b0;
        repeat (14) step();
        chk("t4_not_yet_halted", 32'(halted), 32'd0);
        step();
        chk("t4_halted", 32'(halted), 32'd1);
        chk("t4_fetch_err", 32'(fetch_err), 32'd1);
        chk("t4_pc", pc, 32'h40);
        do_resume();
        chk("t4_err_cleared", 32'(fetch_err), 32'd0);
        instr(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h40);

        // Wrap-around of pc + 4
        instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h44);
        chk("t6_pc_top", pc, 32'hFFFF_FFFC);
        instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
        chk("t6_pc_wrap", pc, 32'h0);

        // Reset while in EXECUTE of an ALU/write-back instruction
        exp_q.push_back(mk(K_FETCH, 32'h0, 16'(exp_ret), 1'b0));
        imem_ack = 1'b1; alu_instr = 1'b1; wb_needed = 1'b1;
        step();
        imem_ack = 1'b0;
        step();
        chk("t6_in_execute", 32'(state), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_no_flag", 32'(flag_en), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; alu_instr = 1'b0; wb_needed = 1'b0;
        exp_ret = 0;
        chk("t6_rst_state", 32'(state), 32'd0);
        chk("t6_rst_pc", pc, 32'h0);
        chk("t6_rst_retired", 32'(retired), 32'd0);
        @(negedge clk);
        chk("t6_rst_no_we", 32'(reg_we), 32'd0);
        @(posedge clk); #1;
        // The FETCH cycle above had no ack; one more clean instruction
        instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("final_pc", pc, 32'h4);
        chk("final_retired", 32'(retired), 32'd1);

        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
